// File: rtl/target_kernel_pkg.sv
// Shared step encoding and width helpers for target_loop_kernel.
// Step numbers are fixed so step_out traces line up across peeled and rolled builds.
package target_kernel_pkg;

  typedef enum logic [4:0] {
    STEP_INIT     = 5'd0,
    STEP_1        = 5'd1,
    STEP_2        = 5'd2,
    STEP_P_K0     = 5'd3,
    STEP_P_SECRET = 5'd4,
    STEP_UNUSED5  = 5'd5,
    STEP_P_INC    = 5'd6,
    STEP_P_T0     = 5'd7,
    STEP_P_T1     = 5'd8,
    STEP_P_T2     = 5'd9,
    STEP_P_T3     = 5'd10,
    STEP_P_OUT    = 5'd11,
    STEP_HEAD     = 5'd12,
    STEP_BRANCH   = 5'd13,
    STEP_SECRET   = 5'd14,
    STEP_DOUBLE   = 5'd15,
    STEP_INC      = 5'd16,
    STEP_T0       = 5'd17,
    STEP_T1       = 5'd18,
    STEP_T2       = 5'd19,
    STEP_T3       = 5'd20,
    STEP_OUT      = 5'd21,
    STEP_DONE     = 5'd22
  } step_e;

  // k must be able to reach ITER itself, hence the +1.
  function automatic int k_width(input int iter);
    return (iter < 1) ? 1 : $clog2(iter + 1);
  endfunction

  function automatic int mod_width(input int modulus);
    return (modulus < 1) ? 1 : $clog2(modulus + 1);
  endfunction

endpackage

// File: rtl/target_mod_unit.sv
// Combinational unsigned remainder dividend % divisor, truncated to OUT_W.
// A zero divisor yields 0 so the unit never produces X before t3 is loaded.
module target_mod_unit #(
  parameter int WIDTH = 4,
  parameter int OUT_W = 2,
  parameter int DIV_W = WIDTH
) (
  input  logic [WIDTH-1:0] dividend,
  input  logic [DIV_W-1:0] divisor,
  output logic [OUT_W-1:0] remainder
);

  localparam int CW = (WIDTH > DIV_W) ? WIDTH : DIV_W;

  logic [CW-1:0] a;
  logic [CW-1:0] b;
  logic [CW-1:0] r;

  assign a         = CW'(dividend);
  assign b         = CW'(divisor);
  assign r         = (b == '0) ? '0 : (a % b);
  assign remainder = OUT_W'(r);

endmodule

// File: rtl/target_loop_kernel.sv
// Cycle-stepped FSM running the compiled loop body for ITER iterations.
// Define PEEL_EN to peel the first iteration into steps 3-11; otherwise the loop is rolled.
module target_loop_kernel
  import target_kernel_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int SECRET_W = 2,
  parameter int OUT_W    = 2,
  parameter int ITER     = 3,
  parameter int OFFSET   = 4,
  parameter int MODULUS  = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stutter_in,
  input  logic [SECRET_W-1:0] secret_in,
  output logic [OUT_W-1:0]    public_out,
  output logic                stutter,
  output logic                done,
  output logic [4:0]          step_out
);

  localparam int               KW       = k_width(ITER);
  localparam int               MW       = mod_width(MODULUS);
  localparam logic [WIDTH-1:0] OFFSET_W = WIDTH'(OFFSET);
  localparam logic [MW-1:0]    MOD_W    = MW'(MODULUS);
  localparam logic [KW-1:0]    ITER_K   = KW'(ITER);

  if (ITER < 1) begin : g_bad_iter
    $error("target_loop_kernel: ITER must be at least 1");
  end
  if (MODULUS < 1) begin : g_bad_mod
    $error("target_loop_kernel: MODULUS must be at least 1");
  end

  step_e            step_reg, step_next;
  logic [WIDTH-1:0] x_reg, x_next;
  logic [KW-1:0]    k_reg, k_next;
  logic [WIDTH-1:0] t0_reg, t0_next;
  logic [WIDTH-1:0] t1_reg, t1_next;
  logic [MW-1:0]    t2_reg, t2_next;
  logic [MW-1:0]    t3_reg, t3_next;
  logic [OUT_W-1:0] out_reg, out_next;
  logic             stutter_reg;
  logic             done_reg, done_next;
  logic [OUT_W-1:0] rem;

  target_mod_unit #(
    .WIDTH (WIDTH),
    .OUT_W (OUT_W),
    .DIV_W (MW)
  ) u_mod (
    .dividend  (t1_reg),
    .divisor   (t3_reg),
    .remainder (rem)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      step_reg    <= STEP_INIT;
      x_reg       <= '0;
      k_reg       <= '0;
      t0_reg      <= '0;
      t1_reg      <= '0;
      t2_reg      <= '0;
      t3_reg      <= '0;
      out_reg     <= '0;
      stutter_reg <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      stutter_reg <= stutter_in;
      step_reg    <= step_next;
      x_reg       <= x_next;
      k_reg       <= k_next;
      t0_reg      <= t0_next;
      t1_reg      <= t1_next;
      t2_reg      <= t2_next;
      t3_reg      <= t3_next;
      out_reg     <= out_next;
      done_reg    <= done_next;
    end
  end

  // Body steps 6-11 and 16-21 perform identical work; only the exit target differs.
  always_comb begin
    step_next = step_reg;
    x_next    = x_reg;
    k_next    = k_reg;
    t0_next   = t0_reg;
    t1_next   = t1_reg;
    t2_next   = t2_reg;
    t3_next   = t3_reg;
    out_next  = out_reg;
    if (!stutter_in) begin
      case (step_reg)
        STEP_INIT: step_next = STEP_1;
`ifdef PEEL_EN
        STEP_1: step_next = STEP_2;
        STEP_2: begin
          x_next    = '0;
          step_next = STEP_P_K0;
        end
        STEP_P_K0: begin
          k_next    = '0;
          step_next = STEP_P_SECRET;
        end
        STEP_P_SECRET: begin
          x_next    = WIDTH'(secret_in);
          step_next = STEP_P_INC;
        end
`else
        STEP_1: begin
          x_next    = '0;
          step_next = STEP_2;
        end
        STEP_2: begin
          k_next    = '0;
          step_next = STEP_HEAD;
        end
`endif
        STEP_P_INC, STEP_INC: begin
          k_next    = k_reg + KW'(1);
          step_next = step_e'(step_reg + 5'd1);
        end
        STEP_P_T0, STEP_T0: begin
          t0_next   = x_reg - OFFSET_W;
          step_next = step_e'(step_reg + 5'd1);
        end
        STEP_P_T1, STEP_T1: begin
          t1_next   = OFFSET_W + t0_reg;
          step_next = step_e'(step_reg + 5'd1);
        end
        STEP_P_T2, STEP_T2: begin
          t2_next   = MW'(k_reg - k_reg);
          step_next = step_e'(step_reg + 5'd1);
        end
        STEP_P_T3, STEP_T3: begin
          t3_next   = t2_reg + MOD_W;
          step_next = step_e'(step_reg + 5'd1);
        end
        STEP_P_OUT, STEP_OUT: begin
          out_next  = rem;
          step_next = STEP_HEAD;
        end
        STEP_HEAD:   step_next = (k_reg < ITER_K) ? STEP_BRANCH : STEP_DONE;
        STEP_BRANCH: step_next = (k_reg == '0) ? STEP_SECRET : STEP_DOUBLE;
        STEP_SECRET: begin
          x_next    = WIDTH'(secret_in);
          step_next = STEP_INC;
        end
        STEP_DOUBLE: begin
          x_next    = x_reg + x_reg;
          step_next = STEP_INC;
        end
        STEP_DONE: step_next = STEP_DONE;
        default:   step_next = STEP_INIT;
      endcase
    end
    done_next = (step_next == STEP_DONE);
  end

  assign public_out = out_reg;
  assign stutter    = stutter_reg;
  assign done       = done_reg;
  assign step_out   = step_reg;

endmodule

// File: tb/tb_target_loop_kernel.sv
// Scoreboard bench: two kernels (defaults, and WIDTH=3/ITER=4) run in lockstep with random
// stutter and secret noise; expected writes come from a plain-arithmetic model of the loop.
module tb_target_loop_kernel;

  typedef struct {
    int value;
    int edge_n;
  } exp_t;

`ifdef PEEL_EN
  localparam int FIRST_WRITE = 11;
  localparam int SAMPLE_EDGE = 5;
`else
  localparam int FIRST_WRITE = 12;
  localparam int SAMPLE_EDGE = 6;
`endif
  localparam int LOOP_LEN = 9;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       stutter_in = 1'b0;
  logic [1:0] secret_a = '0;
  logic [2:0] secret_b = '0;
  logic [1:0] pub_a, pub_b;
  logic       stut_a, stut_b, done_a, done_b;
  logic [4:0] step_a, step_b;

  int   n_vec = 0;
  int   n_fail = 0;
  int   act = 0;
  logic rst_q = 1'b0;
  logic stin_q = 1'b0;
  exp_t q0[$];
  exp_t q1[$];
  int   done_edge [2];
  int   prev_step [2];
  int   prev_pub  [2];
  logic prev_done [2];

  always #5 clk = ~clk;

  target_loop_kernel #(
    .WIDTH(4), .SECRET_W(2), .OUT_W(2), .ITER(3), .OFFSET(4), .MODULUS(3)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .stutter_in(stutter_in), .secret_in(secret_a),
    .public_out(pub_a), .stutter(stut_a), .done(done_a), .step_out(step_a)
  );

  target_loop_kernel #(
    .WIDTH(3), .SECRET_W(3), .OUT_W(2), .ITER(4), .OFFSET(4), .MODULUS(3)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .stutter_in(stutter_in), .secret_in(secret_b),
    .public_out(pub_b), .stutter(stut_b), .done(done_b), .step_out(step_b)
  );

  task automatic check(input string name, input int d, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0d, expected %0d", name, d, got, want);
    end
  endtask

  // Model: x starts at the secret and doubles mod 2^w each pass; output is x mod modulus.
  task automatic push_model(input int d, input int secret, input int w, input int iter,
                            input int modulus, input int out_w);
    longint x = 0;
    exp_t   e;
    for (int i = 0; i < iter; i++) begin
      x = (i == 0) ? longint'(secret) : 2 * x;
      x = x % (longint'(1) << w);
      e.value  = int'((x % modulus) % (longint'(1) << out_w));
      e.edge_n = FIRST_WRITE + LOOP_LEN * i;
      if (d == 0) q0.push_back(e);
      else q1.push_back(e);
    end
    done_edge[d] = FIRST_WRITE + LOOP_LEN * (iter - 1) + 1;
  endtask

  always @(posedge clk) begin
    rst_q  <= rst_n;
    stin_q <= stutter_in;
    if (!rst_n) act <= 0;
    else if (!stutter_in) act <= act + 1;
  end

  always @(negedge clk) begin
    int   st, pb;
    logic so, dn;
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      st = (d == 1) ? int'(step_b) : int'(step_a);
      pb = (d == 1) ? int'(pub_b) : int'(pub_a);
      so = (d == 1) ? stut_b : stut_a;
      dn = (d == 1) ? done_b : done_a;
      if (!rst_q) begin
        check("reset_step", d, st, 0);
        check("reset_out", d, pb, 0);
        check("reset_done", d, int'(dn), 0);
        check("reset_stutter", d, int'(so), 0);
      end else begin
        check("stutter_echo", d, int'(so), int'(stin_q));
        if (stin_q) begin
          check("freeze_step", d, st, prev_step[d]);
          check("freeze_out", d, pb, prev_pub[d]);
          check("freeze_done", d, int'(dn), int'(prev_done[d]));
        end else if (prev_done[d]) begin
          check("done_hold", d, int'(dn), 1);
          check("done_step", d, st, 22);
          check("done_out", d, pb, prev_pub[d]);
        end else begin
          if ((prev_step[d] == 11 || prev_step[d] == 21) && st == 12) begin
            if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
              check("unexpected_write", d, act, -1);
            end else begin
              e = (d == 1) ? q1.pop_front() : q0.pop_front();
              check("write_value", d, pb, e.value);
              check("write_edge", d, act, e.edge_n);
              $display("dut%0d write at edge %0d: public_out=%0d (model %0d)", d, act, pb, e.value);
            end
          end else begin
            check("out_hold", d, pb, prev_pub[d]);
          end
          if (dn && !prev_done[d]) begin
            check("done_edge", d, act, done_edge[d]);
            check("done_step_out", d, st, 22);
            check("writes_pending", d, (d == 1) ? q1.size() : q0.size(), 0);
          end
        end
      end
      prev_step[d] = st;
      prev_pub[d]  = pb;
      prev_done[d] = dn;
    end
  end

  task automatic run(input int sa, input int sb, input int stut_pct, input int burst_at,
                     input int burst_len, input int abort_at);
    int cycles = 0;
    int left   = burst_len;
    rst_n      = 1'b0;
    stutter_in = 1'($urandom_range(0, 1));
    q0.delete();
    q1.delete();
    push_model(0, sa, 4, 3, 3, 2);
    push_model(1, sb, 3, 4, 3, 2);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    while (!(done_a && done_b)) begin
      if (abort_at >= 0 && act == abort_at) begin
        stutter_in = 1'b1;
        rst_n      = 1'b0;
        @(negedge clk);
        return;
      end
      if (burst_at >= 0 && act == burst_at && left > 0) begin
        stutter_in = 1'b1;
        left--;
      end else begin
        stutter_in = ($urandom_range(0, 99) < stut_pct);
      end
      if (act == SAMPLE_EDGE - 1) begin
        secret_a = 2'(sa);
        secret_b = 3'(sb);
      end else begin
        secret_a = 2'($urandom);
        secret_b = 3'($urandom);
      end
      @(negedge clk);
      cycles++;
      if (cycles > 1000) begin
        check("done_timeout", 0, int'(done_a && done_b), 1);
        break;
      end
    end
    repeat (4) begin
      stutter_in = ($urandom_range(0, 99) < 30);
      secret_a   = 2'($urandom);
      secret_b   = 3'($urandom);
      @(negedge clk);
    end
  endtask

  initial begin
    run(1, 5, 0, -1, 0, -1);
    run(2, 5, 0, -1, 0, -1);
    run(3, 5, 0, -1, 0, -1);
    run(1, 5, 0, 7, 5, -1);
    run(1, 5, 20, -1, 0, FIRST_WRITE + 4);
    run(1, 5, 0, -1, 0, -1);
    for (int i = 0; i < 10; i++) begin
      run(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)), 25, -1, 0, -1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
